// File: rtl/ecp3_clkdiv_pkg.sv
// Shared definitions for the ECP3 clock-divider alignment cells:
// FSM encoding, counter widths and parameter legality checks.
package ecp3_clkdiv_pkg;

    localparam int PHASE_W = 3;
    localparam int LOCK_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLIP = 2'd1,
        LOCK = 2'd2
    } state_t;

    function automatic bit is_legal_div(input int div);
        return (div == 2) || (div == 4) || (div == 8);
    endfunction

    function automatic bit is_legal_lockout(input int lockout);
        return (lockout >= 1) && (lockout <= 15);
    endfunction

endpackage

// File: rtl/rise_det.sv
// CE-qualified registered rising-edge detector. The history register only
// advances on enabled cycles, so a level held across a CE gap still counts.
module rise_det (
    input  logic CLK,
    input  logic RSTN,
    input  logic CE,
    input  logic D,
    output logic RISE
);

    logic d_q;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            d_q <= 1'b0;
        end else if (CE) begin
            d_q <= D;
        end
    end

    assign RISE = CE & D & ~d_q;

endmodule

// File: rtl/clkdiv_align.sv
// Divided clock-enable generator with ALIGNWD phase slip and lockout window.
// STATE is a debug view of the slip FSM; all outputs decode registers only.
module clkdiv_align
    import ecp3_clkdiv_pkg::*;
#(
    parameter int DIV     = 4,
    parameter int LOCKOUT = 4
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               CE,
    input  logic               ALIGNWD,
    output logic               CDIVE,
    output logic [PHASE_W-1:0] PHASE,
    output logic               SLIPPED,
    output logic               BUSY,
    output state_t             STATE
);

    generate
        if (!is_legal_div(DIV)) begin : g_bad_div
            $error("clkdiv_align: DIV must be 2, 4 or 8");
        end
        if (!is_legal_lockout(LOCKOUT)) begin : g_bad_lockout
            $error("clkdiv_align: LOCKOUT must be in 1..15");
        end
    endgenerate

    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(DIV - 1);
    localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCKOUT - 1);

    logic               rise;
    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_inc;
    logic [LOCK_W-1:0]  lock_cnt_q;

    rise_det u_rise_det (
        .CLK  (CLK),
        .RSTN (RSTN),
        .CE   (CE),
        .D    (ALIGNWD),
        .RISE (rise)
    );

    assign phase_inc = (phase_q == PHASE_MAX) ? '0 : phase_q + PHASE_W'(1);

    // The only cycle the phase counter does not advance while enabled is the
    // edge that accepts a slip; that missing increment is the slip itself.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            lock_cnt_q <= '0;
        end else if (CE) begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= SLIP;
                    end else begin
                        phase_q <= phase_inc;
                    end
                end
                SLIP: begin
                    phase_q    <= phase_inc;
                    lock_cnt_q <= LOCK_LOAD;
                    state_q    <= LOCK;
                end
                LOCK: begin
                    phase_q <= phase_inc;
                    if (lock_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        lock_cnt_q <= lock_cnt_q - LOCK_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign CDIVE   = (phase_q == PHASE_MAX);
    assign PHASE   = phase_q;
    assign SLIPPED = (state_q == SLIP);
    assign BUSY    = (state_q != IDLE);
    assign STATE   = state_q;

    phase_in_range: assert property (@(posedge CLK) disable iff (!RSTN) phase_q <= PHASE_MAX);

endmodule

// File: tb/tb_clkdiv_align.sv
// Bench for clkdiv_align: two instances (DIV=4/LOCKOUT=4, DIV=8/LOCKOUT=3)
// share stimulus and are compared every cycle against a countdown model.
module tb_clkdiv_align;
    import ecp3_clkdiv_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rstn;
    logic ce;
    logic alignwd;
    always #5 clk = ~clk;

    logic       cdive4, slipped4, busy4;
    logic [2:0] phase4;
    state_t     state4;
    logic       cdive8, slipped8, busy8;
    logic [2:0] phase8;
    state_t     state8;

    clkdiv_align #(.DIV(4), .LOCKOUT(4)) dut4 (
        .CLK(clk), .RSTN(rstn), .CE(ce), .ALIGNWD(alignwd),
        .CDIVE(cdive4), .PHASE(phase4), .SLIPPED(slipped4), .BUSY(busy4), .STATE(state4)
    );

    clkdiv_align #(.DIV(8), .LOCKOUT(3)) dut8 (
        .CLK(clk), .RSTN(rstn), .CE(ce), .ALIGNWD(alignwd),
        .CDIVE(cdive8), .PHASE(phase8), .SLIPPED(slipped8), .BUSY(busy8), .STATE(state8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: busy_left counts the remaining busy cycles after a slip
    int div_of[2]  = '{4, 8};
    int lock_of[2] = '{4, 3};
    int m_phase[2];
    int m_busy_left[2];
    bit m_slipped[2];
    bit m_prev;

    task automatic model_step(input bit r, input bit c, input bit a);
        bit rise;
        if (!r) begin
            m_prev = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_phase[i]     = 0;
                m_busy_left[i] = 0;
                m_slipped[i]   = 1'b0;
            end
        end else if (c) begin
            rise   = a && !m_prev;
            m_prev = a;
            for (int i = 0; i < 2; i++) begin
                if (m_busy_left[i] == 0 && rise) begin
                    m_slipped[i]   = 1'b1;
                    m_busy_left[i] = lock_of[i] + 1;
                end else begin
                    m_phase[i]   = (m_phase[i] + 1) % div_of[i];
                    m_slipped[i] = 1'b0;
                    if (m_busy_left[i] > 0) m_busy_left[i]--;
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [2:0] ph, input logic cd,
                              input logic sl, input logic bs, input state_t st);
        string p;
        p = (i == 0) ? "d4" : "d8";
        check({p, "_phase"},   {5'd0, ph}, 8'(m_phase[i]));
        check({p, "_cdive"},   {7'd0, cd}, {7'd0, m_phase[i] == div_of[i] - 1});
        check({p, "_slipped"}, {7'd0, sl}, {7'd0, m_slipped[i]});
        check({p, "_busy"},    {7'd0, bs}, {7'd0, m_busy_left[i] > 0});
        check({p, "_idle"},    {7'd0, st == IDLE}, {7'd0, m_busy_left[i] == 0});
    endtask

    // driver: inputs change on the falling edge, outputs sampled on the next one
    task automatic step(input bit r, input bit c, input bit a);
        rstn    = r;
        ce      = c;
        alignwd = a;
        @(posedge clk);
        #1;
        model_step(r, c, a);
        @(negedge clk);
        check_inst(0, phase4, cdive4, slipped4, busy4, state4);
        check_inst(1, phase8, cdive8, slipped8, busy8, state8);
    endtask

    task automatic go_phase(input int i, input int p);
        int n;
        n = 0;
        while (m_phase[i] != p && n < 20) begin
            step(1, 1, 0);
            n++;
        end
        if (m_phase[i] != p) check("align_timeout", 8'(m_phase[i]), 8'(p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a_rand;
        rstn = 1'b0; ce = 1'b1; alignwd = 1'b0;
        @(negedge clk);

        // reset with ALIGNWD toggling, then free run
        step(0, 1, 1); step(0, 1, 0); step(0, 1, 1);
        check("rst_phase", {5'd0, phase4}, 8'd0);
        check("rst_busy",  {7'd0, busy4},  8'd0);
        step(1, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 0);
        check("run_phase", {5'd0, phase4}, 8'd1);

        // basic slip at phase 1, second rise inside lockout, third after it
        go_phase(0, 1);
        step(1, 1, 1);
        check("slip_hold", {5'd0, phase4}, 8'd1);
        check("slip_flag", {7'd0, slipped4}, 8'd1);
        step(1, 1, 0);
        step(1, 1, 1);
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        check("lock_end_busy", {7'd0, busy4}, 8'd0);
        step(1, 1, 1);
        check("reslip_flag", {7'd0, slipped4}, 8'd1);
        for (int k = 0; k < 6; k++) step(1, 1, 0);

        // slip at wrap on the DIV=8 instance
        go_phase(1, 7);
        step(1, 1, 1);
        check("wrap_cdive", {7'd0, cdive8}, 8'd1);
        step(1, 1, 0);
        check("wrap_phase", {5'd0, phase8}, 8'd0);
        for (int k = 0; k < 6; k++) step(1, 1, 0);

        // CE gap with an ALIGNWD pulse inside it
        go_phase(0, 2);
        step(1, 0, 0); step(1, 0, 1); step(1, 0, 1); step(1, 0, 0); step(1, 0, 0);
        check("ce_frozen", {5'd0, phase4}, 8'd2);
        step(1, 1, 0);
        check("ce_resume", {5'd0, phase4}, 8'd3);

        // rise held across a CE gap counts once CE returns
        for (int k = 0; k < 6; k++) step(1, 1, 0);
        step(1, 0, 1); step(1, 0, 1); step(1, 1, 1);
        check("ce_late_rise", {7'd0, slipped4}, 8'd1);

        // ALIGNWD held high is a single rise
        for (int k = 0; k < 10; k++) step(1, 1, 1);
        for (int k = 0; k < 6; k++) step(1, 1, 0);

        // reset during LOCK, then an immediate new slip
        step(1, 1, 1); step(1, 1, 0); step(1, 1, 0);
        step(0, 1, 0);
        check("rst_lock_busy",  {7'd0, busy4},  8'd0);
        check("rst_lock_phase", {5'd0, phase4}, 8'd0);
        step(1, 1, 1);
        check("post_rst_slip", {7'd0, slipped4}, 8'd1);

        // randomized traffic
        a_rand = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) == 0) a_rand = ~a_rand;
            step($urandom_range(0, 60) != 0, $urandom_range(0, 4) != 0, a_rand);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
